instrumented_adder_meter: RTL and testbench

- Parametrised measurement controller for instrumented ring-oscillator adders; successor to the fixed 32-bit single-shot wrapper.
- Drives the adder's operands and its ring-bit and sum-bit select masks, enables the ring, and counts ring edges over a programmable window of wb_clk_i cycles.
- Adds averaging over 2^AVG_LOG2 runs, a saturating counter with overflow flag, continuous mode, and abort.
- Sits between the LA/IO decode logic and the adder-under-test inside the wrapped project.

---
 rtl/instrumented_adder_meter_if.sv | 40 ++++
 rtl/instrumented_adder_meter.sv | 146 ++++++++++++++
 tb/tb_instrumented_adder_meter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instrumented_adder_meter_if.sv
// Bus between the LA/IO decode logic (master) and the ring-oscillator adder meter (slave).
// chain_in is the asynchronous ring output returned by the adder under test.
interface instrumented_adder_meter_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WIN_W    = 16,
  parameter int unsigned AVG_LOG2 = 2
);
  localparam int unsigned AVG_SEL_W = (AVG_LOG2 > 0) ? $clog2(AVG_LOG2 + 1) : 1;
  localparam int unsigned BIT_SEL_W = $clog2(WIDTH);

  logic                 active;
  logic                 start;
  logic                 abort;
  logic                 cont;
  logic [AVG_SEL_W-1:0] avg_sel;
  logic [BIT_SEL_W-1:0] bit_sel;
  logic [WIDTH-1:0]     a_in;
  logic [WIDTH-1:0]     b_in;
  logic [WIN_W-1:0]     window;
  logic                 chain_in;
  logic [WIDTH-1:0]     a_out;
  logic [WIDTH-1:0]     b_out;
  logic [WIDTH-1:0]     ring_mask;
  logic [WIDTH-1:0]     sum_mask;
  logic                 busy;
  logic                 done;
  logic [CNT_W-1:0]     result;
  logic                 overflow;

  modport master (
    output active, start, abort, cont, avg_sel, bit_sel, a_in, b_in, window, chain_in,
    input  a_out, b_out, ring_mask, sum_mask, busy, done, result, overflow
  );

  modport slave (
    input  active, start, abort, cont, avg_sel, bit_sel, a_in, b_in, window, chain_in,
    output a_out, b_out, ring_mask, sum_mask, busy, done, result, overflow
  );
endinterface

// File: rtl/instrumented_adder_meter.sv
// Measurement controller for a ring-oscillator adder: drives operands and masks, counts
// synchronised ring edges over a window, averages 2^avg_sel runs, optional continuous mode.
module instrumented_adder_meter #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned AVG_LOG2   = 2
) (
  input logic                       wb_clk_i,
  input logic                       wb_rst_n,
  instrumented_adder_meter_if.slave bus
);
  localparam int unsigned AVG_SEL_W = (AVG_LOG2 > 0) ? $clog2(AVG_LOG2 + 1) : 1;
  localparam int unsigned BIT_SEL_W = $clog2(WIDTH);
  localparam int unsigned SET_W     = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TMR_W     = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam int unsigned ACC_W     = CNT_W + AVG_LOG2;
  localparam int unsigned RUN_W     = AVG_LOG2 + 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SETTLE, COUNT, ACCUM, DONE} state_t;

  state_t               state, state_next;
  logic [1:0]           start_q;
  logic [2:0]           sync;
  logic [WIDTH-1:0]     a_r, b_r;
  logic [BIT_SEL_W-1:0] bit_r;
  logic [WIN_W-1:0]     win_r;
  logic [AVG_SEL_W-1:0] avg_r;
  logic                 cont_r;
  logic [TMR_W-1:0]     tmr;
  logic [RUN_W-1:0]     runs;
  logic [CNT_W-1:0]     cnt;
  logic                 sat_run, sat_any;
  logic [ACC_W-1:0]     acc;
  logic [CNT_W-1:0]     result_r;
  logic                 ovf_r;

  logic                 rise, edge_det, capture;
  logic [AVG_SEL_W-1:0] avg_clamped;
  logic [TMR_W-1:0]     win_last;
  logic [RUN_W-1:0]     runs_next, runs_target;
  logic [ACC_W-1:0]     acc_next;
  logic [WIDTH-1:0]     mask;

  assign rise        = start_q[0] & ~start_q[1];
  assign edge_det    = sync[1] & ~sync[2];
  assign avg_clamped = (bus.avg_sel > AVG_SEL_W'(AVG_LOG2)) ? AVG_SEL_W'(AVG_LOG2) : bus.avg_sel;
  // A zero window is stretched to one count cycle.
  assign win_last    = (win_r == '0) ? '0 : TMR_W'(win_r) - TMR_W'(1);
  assign runs_next   = runs + RUN_W'(1);
  assign runs_target = RUN_W'(1) << avg_r;
  assign acc_next    = acc + ACC_W'(cnt);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n)       state <= IDLE;
    else if (!bus.active) state <= IDLE;
    else                 state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE:    if (rise) begin state_next = SETUP; capture = 1'b1; end
      SETUP:   state_next = SETTLE;
      SETTLE:  if (tmr == SETTLE_LAST) state_next = COUNT;
      COUNT:   if (tmr == win_last) state_next = ACCUM;
      ACCUM:   state_next = (runs_next < runs_target) ? SETUP : DONE;
      DONE: begin
        if (cont_r && bus.start) begin state_next = SETUP; capture = 1'b1; end
        else                     state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything, including a start seen in the same cycle.
    if (bus.abort) begin
      state_next = IDLE;
      capture    = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n || !bus.active) begin
      start_q  <= '0;
      sync     <= '0;
      a_r      <= '0;
      b_r      <= '0;
      bit_r    <= '0;
      win_r    <= '0;
      avg_r    <= '0;
      cont_r   <= 1'b0;
      tmr      <= '0;
      runs     <= '0;
      cnt      <= '0;
      sat_run  <= 1'b0;
      sat_any  <= 1'b0;
      acc      <= '0;
      result_r <= '0;
      ovf_r    <= 1'b0;
    end else begin
      start_q <= {start_q[0], bus.start};
      sync    <= {sync[1:0], bus.chain_in};
      tmr     <= (state_next != state) ? '0 : tmr + TMR_W'(1);
      if (capture) begin
        a_r     <= bus.a_in;
        b_r     <= bus.b_in;
        bit_r   <= bus.bit_sel;
        win_r   <= bus.window;
        avg_r   <= avg_clamped;
        cont_r  <= bus.cont;
        acc     <= '0;
        runs    <= '0;
        cnt     <= '0;
        sat_run <= 1'b0;
        sat_any <= 1'b0;
      end
      if (state == COUNT && edge_det) begin
        if (cnt == '1) sat_run <= 1'b1;
        else           cnt     <= cnt + CNT_W'(1);
      end
      if (state == ACCUM) begin
        acc     <= acc_next;
        runs    <= runs_next;
        cnt     <= '0;
        sat_run <= 1'b0;
        sat_any <= sat_any | sat_run;
        if (state_next == DONE) begin
          result_r <= CNT_W'(acc_next >> avg_r);
          ovf_r    <= sat_any | sat_run;
        end
      end
    end
  end

  assign mask          = (state == SETTLE || state == COUNT) ? (WIDTH'(1) << bit_r) : '0;
  assign bus.a_out     = a_r;
  assign bus.b_out     = b_r;
  assign bus.ring_mask = mask;
  assign bus.sum_mask  = mask;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.result    = result_r;
  assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_instrumented_adder_meter.sv
// Bench for instrumented_adder_meter: timeline-based reference model checked every cycle,
// plus directed measurements with hand-computed results and latencies.
module tb_instrumented_adder_meter;
  localparam int unsigned WIDTH      = 16;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned WIN_W      = 8;
  localparam int unsigned SETTLE_CYC = 4;
  localparam int unsigned AVG_LOG2   = 2;
  localparam int unsigned S          = SETTLE_CYC;
  localparam int unsigned MAXC       = (1 << CNT_W) - 1;
  localparam int unsigned NMAX       = 40000;
  localparam int unsigned BSW        = $clog2(WIDTH);
  localparam int unsigned ASW        = $clog2(AVG_LOG2 + 1);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  instrumented_adder_meter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .AVG_LOG2(AVG_LOG2)) bus ();

  instrumented_adder_meter #(
    .WIDTH(WIDTH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(SETTLE_CYC), .AVG_LOG2(AVG_LOG2)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: each measurement is a timeline of runs of S+W+2 cycles after capture.
  bit           chs [NMAX];
  bit           sts [NMAX];
  int unsigned  n = 1;
  bit           m_meas = 0;
  int unsigned  m_k, m_c, m_W, m_P, m_D, m_avg, m_bit;
  bit           m_cont;
  logic [WIDTH-1:0] m_a = '0, m_b = '0;
  int unsigned  m_res = 0;
  bit           m_ovf = 0;

  task automatic m_capture(input int unsigned at);
    m_meas = 1; m_k = 0; m_c = at;
    m_a = bus.a_in; m_b = bus.b_in; m_bit = int'(bus.bit_sel);
    m_W = (bus.window == 0) ? 1 : int'(bus.window);
    m_avg = (int'(bus.avg_sel) > AVG_LOG2) ? AVG_LOG2 : int'(bus.avg_sel);
    m_cont = bus.cont;
    m_P = S + m_W + 2;
    m_D = (1 << m_avg) * m_P;
  endtask

  // A rising edge of the ring seen at cycle m needs samples (m-1)=1 and (m-2)=0.
  task automatic m_finish();
    int unsigned acc = 0;
    bit ov = 0;
    for (int unsigned r = 0; r < (1 << m_avg); r++) begin
      int unsigned e = 0;
      int unsigned lo = m_c + r * m_P + S + 1;
      for (int unsigned m = lo; m < lo + m_W; m++)
        if (chs[m-1] && !chs[m-2]) e++;
      if (e > MAXC) begin ov = 1; e = MAXC; end
      acc += e;
    end
    m_res = acc >> m_avg;
    m_ovf = ov;
  endtask

  initial forever begin
    @(posedge clk);
    n++;
    if (n >= NMAX) begin
      $display("FAIL model_capacity: got %0d cycles expected below %0d", n, NMAX);
      $fatal(1);
    end
    if (!rst_n || !bus.active) begin
      chs[n] = 0; sts[n] = 0; m_meas = 0;
      m_a = '0; m_b = '0; m_res = 0; m_ovf = 0;
    end else begin
      chs[n] = bus.chain_in; sts[n] = bus.start;
      if (m_meas) begin
        if (bus.abort) m_meas = 0;
        else if (m_k == m_D) begin
          if (m_cont && bus.start) m_capture(n);
          else m_meas = 0;
        end else begin
          m_k++;
          if (m_k == m_D) m_finish();
        end
      end else if (sts[n-1] && !sts[n-2] && !bus.abort) m_capture(n);
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [WIDTH-1:0] em;
      logic eb, ed;
      em = '0; eb = 0; ed = 0;
      if (m_meas) begin
        eb = 1;
        if (m_k == m_D) ed = 1;
        else if ((m_k % m_P) >= 1 && (m_k % m_P) <= S + m_W) em = WIDTH'(1) << m_bit;
      end
      check("busy", 64'(bus.busy), 64'(eb));
      check("done", 64'(bus.done), 64'(ed));
      check("ring_mask", 64'(bus.ring_mask), 64'(em));
      check("sum_mask", 64'(bus.sum_mask), 64'(em));
      check("a_out", 64'(bus.a_out), 64'(m_a));
      check("b_out", 64'(bus.b_out), 64'(m_b));
      check("result", 64'(bus.result), 64'(m_res));
      check("overflow", 64'(bus.overflow), 64'(m_ovf));
    end
  end

  // Ring stimulus: 0 = static low, 1 = toggle every ch_hp cycles, 2 = random.
  int unsigned ch_mode = 0, ch_hp = 1, ch_cnt = 0;
  initial forever begin
    @(posedge clk);
    #2;
    case (ch_mode)
      0: bus.chain_in = 1'b0;
      1: begin
        ch_cnt++;
        if (ch_cnt >= ch_hp) begin ch_cnt = 0; bus.chain_in = ~bus.chain_in; end
      end
      default: bus.chain_in = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic launch(input int unsigned win, input int unsigned avg, input int unsigned bs);
    @(posedge clk);
    #1;
    bus.a_in = WIDTH'($urandom); bus.b_in = WIDTH'($urandom);
    bus.bit_sel = BSW'(bs); bus.window = WIN_W'(win); bus.avg_sel = ASW'(avg);
    bus.start = 1'b1;
  endtask

  // Latency counts cycles from the edge that first samples start high.
  task automatic await_done(output int unsigned lat, output logic [CNT_W-1:0] res,
                            output logic ovf, output logic [WIDTH-1:0] mask_or);
    bit got = 0;
    lat = 0; res = '0; ovf = 0; mask_or = '0;
    for (int unsigned i = 1; i <= 600 && !got; i++) begin
      @(negedge clk);
      mask_or |= bus.ring_mask;
      if (bus.done) begin got = 1; lat = i - 2; res = bus.result; ovf = bus.overflow; end
    end
    check("done_timeout", 64'(got), 64'(1));
  endtask

  task automatic wait_idle(input int unsigned max);
    bit got = 0;
    for (int unsigned i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (!bus.busy) got = 1;
    end
    check("idle_timeout", 64'(got), 64'(1));
  endtask

  task automatic finish_run();
    @(posedge clk);
    #1 bus.start = 1'b0; bus.cont = 1'b0;
    wait_idle(800);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int unsigned lat, sp, extra;
    logic [CNT_W-1:0] res;
    logic ovf;
    logic [WIDTH-1:0] mo;
    bit seen;

    bus.active = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.cont = 1'b0;
    bus.avg_sel = '0; bus.bit_sel = '0; bus.a_in = '0; bus.b_in = '0;
    bus.window = '0; bus.chain_in = 1'b0;
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_mask", 64'(bus.ring_mask), 64'(0));
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Single run, ring toggling every 2 clocks: 12-cycle window holds exactly 3 rising edges.
    ch_mode = 1; ch_hp = 2;
    launch(12, 0, 5);
    await_done(lat, res, ovf, mo);
    check("single_latency", 64'(lat), 64'(19));
    check("single_result", 64'(res), 64'(3));
    check("single_mask", 64'(mo), 64'(16'h0020));
    finish_run();

    // Same ring, 10-cycle window; value depends on phase and is left to the model.
    launch(10, 0, 3);
    await_done(lat, res, ovf, mo);
    check("win10_latency", 64'(lat), 64'(17));
    finish_run();

    // Averaging: 4 runs x 4 edges, one done pulse.
    ch_mode = 1; ch_hp = 1;
    launch(8, 2, 7);
    await_done(lat, res, ovf, mo);
    check("avg_result", 64'(res), 64'(4));
    check("avg_overflow", 64'(ovf), 64'(0));
    extra = 0;
    repeat (30) begin @(negedge clk); if (bus.done) extra++; end
    check("avg_single_done", 64'(extra), 64'(0));
    finish_run();

    // Saturation: 40 edges into a 5-bit counter.
    launch(80, 0, 1);
    await_done(lat, res, ovf, mo);
    check("sat_result", 64'(res), 64'(MAXC));
    check("sat_overflow", 64'(ovf), 64'(1));
    finish_run();

    // Continuous mode, then abort.
    bus.cont = 1'b1;
    launch(10, 0, 2);
    await_done(lat, res, ovf, mo);
    check("cont_result", 64'(res), 64'(5));
    sp = 0;
    for (int unsigned i = 1; i <= 200 && sp == 0; i++) begin
      @(negedge clk);
      if (bus.done) sp = i;
    end
    check("cont_spacing", 64'(sp), 64'(1 + S + 10 + 2));
    repeat (5) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(bus.busy), 64'(0));
    seen = 0;
    repeat (40) begin @(negedge clk); if (bus.done || bus.busy) seen = 1; end
    check("abort_no_done", 64'(seen), 64'(0));
    check("abort_result_held", 64'(bus.result), 64'(5));
    finish_run();

    // Window 0 acts as 1, top bit selected.
    launch(0, 0, WIDTH - 1);
    await_done(lat, res, ovf, mo);
    check("win0_latency", 64'(lat), 64'(1 + 1 + S + 1 + 1));
    check("topbit_mask", 64'(mo), 64'(16'h8000));
    finish_run();

    // Static ring gives zero.
    ch_mode = 0;
    launch(20, 1, 4);
    await_done(lat, res, ovf, mo);
    check("static_result", 64'(res), 64'(0));
    finish_run();

    // Asynchronous reset in the middle of COUNT.
    ch_mode = 1; ch_hp = 1;
    launch(30, 0, 9);
    repeat (12) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_mask", 64'(bus.ring_mask), 64'(0));
    check("arst_a_out", 64'(bus.a_out), 64'(0));
    check("arst_result", 64'(bus.result), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    @(posedge clk);
    #1 bus.start = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Randomised measurements with aborts, active drops and input churn.
    for (int t = 0; t < 40; t++) begin
      int unsigned act_sel;
      ch_mode = $urandom_range(0, 2); ch_hp = $urandom_range(1, 5);
      bus.cont = ($urandom_range(0, 3) == 0);
      launch($urandom_range(0, 30), $urandom_range(0, 3), $urandom_range(0, WIDTH - 1));
      repeat (3) @(posedge clk);
      #1;
      bus.a_in = WIDTH'($urandom); bus.b_in = WIDTH'($urandom);
      bus.window = WIN_W'($urandom); bus.avg_sel = ASW'($urandom);
      bus.bit_sel = BSW'($urandom);
      act_sel = $urandom_range(0, 5);
      repeat ($urandom_range(1, 120)) @(posedge clk);
      #1;
      if (act_sel == 0) begin
        bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
      end else if (act_sel == 1) begin
        bus.active = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1 bus.active = 1'b1;
      end
      bus.start = 1'b0;
      wait_idle(800);
      bus.cont = 1'b0;
      repeat (2) @(posedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
